// File: rtl/alarm_controller.sv
// Alarm stage fed by the time-of-day counter: stores an HH:MM alarm time and
// rings, snoozes or times out according to edge-detected user requests.
module alarm_controller #(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic       enable,
  input  logic [1:0] set_select,
  input  logic       set_inc,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [5:0] alarm_min,
  output logic [4:0] alarm_hour,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam int unsigned SNZ_TICKS = SNOOZE_MINUTES * 60;
  localparam int unsigned RW        = $clog2(RING_SECONDS + 1);
  localparam int unsigned SW        = $clog2(SNZ_TICKS + 1);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_TICKS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RINGING = 2'd1;
  localparam logic [1:0] SNOOZE  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [RW-1:0] ring_cnt, ring_cnt_nxt;
  logic [SW-1:0] snz_cnt, snz_cnt_nxt;

  logic       set_inc_prev, snooze_prev, dismiss_prev;
  logic [5:0] sec_prev;
  logic       match_prev;

  logic set_inc_pulse, snooze_pulse, dismiss_pulse;
  logic sec_tick, match, match_rise;

  assign set_inc_pulse = set_inc & ~set_inc_prev;
  assign snooze_pulse  = snooze  & ~snooze_prev;
  assign dismiss_pulse = dismiss & ~dismiss_prev;
  assign sec_tick      = (sec_in != sec_prev);
  assign match         = (hour_in == alarm_hour) && (min_in == alarm_min) && (sec_in == '0);
  assign match_rise    = match & ~match_prev;

  assign ringing  = (state == RINGING);
  assign snoozing = (state == SNOOZE);

  // Priority: ~enable > dismiss > snooze > tick/timeout.
  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    snz_cnt_nxt  = snz_cnt;
    case (state)
      IDLE: begin
        if (enable && match_rise) begin
          state_nxt    = RINGING;
          ring_cnt_nxt = '0;
        end
      end
      RINGING: begin
        if (!enable || dismiss_pulse) begin
          state_nxt = IDLE;
        end else if (snooze_pulse) begin
          state_nxt   = SNOOZE;
          snz_cnt_nxt = SNZ_LOAD;
        end else if (sec_tick) begin
          if (ring_cnt == RING_LAST) state_nxt = IDLE;
          else ring_cnt_nxt = ring_cnt + 1'b1;
        end
      end
      SNOOZE: begin
        if (!enable || dismiss_pulse) begin
          state_nxt = IDLE;
        end else if (sec_tick) begin
          if (snz_cnt == SW'(1)) begin
            state_nxt    = RINGING;
            ring_cnt_nxt = '0;
          end else begin
            snz_cnt_nxt = snz_cnt - 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      set_inc_prev <= 1'b0;
      snooze_prev  <= 1'b0;
      dismiss_prev <= 1'b0;
      sec_prev     <= '0;
      match_prev   <= 1'b1;
      alarm_min    <= '0;
      alarm_hour   <= '0;
      buzzer       <= 1'b0;
    end else begin
      state        <= state_nxt;
      ring_cnt     <= ring_cnt_nxt;
      snz_cnt      <= snz_cnt_nxt;
      set_inc_prev <= set_inc;
      snooze_prev  <= snooze;
      dismiss_prev <= dismiss;
      sec_prev     <= sec_in;
      match_prev   <= match;
      buzzer       <= (state == RINGING) && !sec_in[0];
      if (set_inc_pulse) begin
        case (set_select)
          2'd1:    alarm_min  <= (alarm_min == 6'd59) ? '0 : alarm_min + 6'd1;
          2'd2:    alarm_hour <= (alarm_hour == 5'd23) ? '0 : alarm_hour + 5'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: a hand-written vector table for the corner cases,
// then random traffic, all checked against a time-of-day level model.
module tb_alarm_controller;

  localparam int unsigned RS = 3;
  localparam int unsigned SM = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] sec_in = '0, min_in = '0;
  logic [4:0] hour_in = '0;
  logic       enable = 1'b1;
  logic [1:0] set_select = '0;
  logic       set_inc = 1'b0, snooze = 1'b0, dismiss = 1'b0;
  logic [5:0] alarm_min;
  logic [4:0] alarm_hour;
  logic       ringing, snoozing, buzzer;

  alarm_controller #(.RING_SECONDS(RS), .SNOOZE_MINUTES(SM)) dut (
    .clk(clk), .reset(reset), .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
    .enable(enable), .set_select(set_select), .set_inc(set_inc), .snooze(snooze),
    .dismiss(dismiss), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    int         t;      // time of day in seconds
    logic       en;
    logic [1:0] sel;
    logic       inc, snz, dis;
    bit         chk;
    logic       ring, snzg, buzz;
    int         am, ah;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   e_am  = 0;
  int   e_ah  = 0;

  // Reference model: alarm kept as minutes-of-day, ring/snooze as seconds remaining.
  typedef enum {M_IDLE, M_RING, M_SNZ} mode_t;
  mode_t m_mode;
  int    m_alarm, m_ring_left, m_snz_left;
  int    m_sec_prev;
  bit    m_match_prev, m_inc_prev, m_snz_prev, m_dis_prev, m_buzz;

  function automatic int T(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic a(input int t, input logic en, input logic [1:0] sel,
                   input logic inc, input logic snz, input logic dis);
    vec_t v;
    v.rst = 1'b0; v.t = t; v.en = en; v.sel = sel; v.inc = inc; v.snz = snz; v.dis = dis;
    v.chk = 1'b0; v.ring = 1'b0; v.snzg = 1'b0; v.buzz = 1'b0; v.am = 0; v.ah = 0;
    tbl.push_back(v);
  endtask

  task automatic c(input int t, input logic en, input logic [1:0] sel,
                   input logic inc, input logic snz, input logic dis,
                   input logic ring, input logic snzg, input logic buzz);
    vec_t v;
    v.rst = 1'b0; v.t = t; v.en = en; v.sel = sel; v.inc = inc; v.snz = snz; v.dis = dis;
    v.chk = 1'b1; v.ring = ring; v.snzg = snzg; v.buzz = buzz; v.am = e_am; v.ah = e_ah;
    tbl.push_back(v);
  endtask

  task automatic model_update(input vec_t v);
    int  s, mi, h;
    bit  inc_p, snz_p, dis_p, tick, match, rise;
    s = v.t % 60; mi = (v.t / 60) % 60; h = v.t / 3600;
    if (v.rst) begin
      m_mode = M_IDLE; m_alarm = 0; m_ring_left = 0; m_snz_left = 0;
      m_sec_prev = 0; m_match_prev = 1; m_inc_prev = 0; m_snz_prev = 0; m_dis_prev = 0;
      m_buzz = 0;
      return;
    end
    inc_p = v.inc && !m_inc_prev;
    snz_p = v.snz && !m_snz_prev;
    dis_p = v.dis && !m_dis_prev;
    tick  = (s != m_sec_prev);
    match = (h * 60 + mi == m_alarm) && (s == 0);
    rise  = match && !m_match_prev;
    m_buzz = (m_mode == M_RING) && (s % 2 == 0);
    if (m_mode == M_IDLE) begin
      if (v.en && rise) begin m_mode = M_RING; m_ring_left = RS; end
    end else if (!v.en || dis_p) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_RING) begin
      if (snz_p) begin m_mode = M_SNZ; m_snz_left = SM * 60; end
      else if (tick) begin
        m_ring_left--;
        if (m_ring_left == 0) m_mode = M_IDLE;
      end
    end else if (tick) begin
      m_snz_left--;
      if (m_snz_left == 0) begin m_mode = M_RING; m_ring_left = RS; end
    end
    if (inc_p && v.sel == 2'd1) m_alarm = (m_alarm / 60) * 60 + (m_alarm % 60 + 1) % 60;
    if (inc_p && v.sel == 2'd2) m_alarm = ((m_alarm / 60 + 1) % 24) * 60 + m_alarm % 60;
    m_sec_prev = s; m_match_prev = match;
    m_inc_prev = v.inc; m_snz_prev = v.snz; m_dis_prev = v.dis;
  endtask

  task automatic step(input vec_t v, input string tag, input int idx);
    reset = v.rst; enable = v.en; set_select = v.sel;
    set_inc = v.inc; snooze = v.snz; dismiss = v.dis;
    sec_in = 6'(v.t % 60); min_in = 6'((v.t / 60) % 60); hour_in = 5'(v.t / 3600);
    @(posedge clk);
    model_update(v);
    #1;
    n_vec++;
    if (ringing !== (m_mode == M_RING) || snoozing !== (m_mode == M_SNZ) || buzzer !== m_buzz ||
        alarm_min !== 6'(m_alarm % 60) || alarm_hour !== 5'(m_alarm / 60)) begin
      n_bad++;
      $display("FAIL model %s[%0d]: got ring=%b snz=%b buzz=%b alarm=%0d:%0d, want ring=%b snz=%b buzz=%b alarm=%0d:%0d",
               tag, idx, ringing, snoozing, buzzer, alarm_hour, alarm_min,
               m_mode == M_RING, m_mode == M_SNZ, m_buzz, m_alarm / 60, m_alarm % 60);
    end
    if (v.chk) begin
      n_vec++;
      if (ringing !== v.ring || snoozing !== v.snzg || buzzer !== v.buzz ||
          alarm_min !== 6'(v.am) || alarm_hour !== 5'(v.ah)) begin
        n_bad++;
        $display("FAIL table %s[%0d]: got ring=%b snz=%b buzz=%b alarm=%0d:%0d, want ring=%b snz=%b buzz=%b alarm=%0d:%0d",
                 tag, idx, ringing, snoozing, buzzer, alarm_hour, alarm_min,
                 v.ring, v.snzg, v.buzz, v.ah, v.am);
      end
    end
  endtask

  initial begin
    vec_t v;
    int   t;

    // Reset with time 00:00:00 and enable high: nothing rings afterwards.
    v.rst = 1'b1; v.t = 0; v.en = 1'b1; v.sel = '0; v.inc = 0; v.snz = 0; v.dis = 0;
    v.chk = 1'b1; v.ring = 0; v.snzg = 0; v.buzz = 0; v.am = 0; v.ah = 0;
    tbl.push_back(v); tbl.push_back(v);
    for (int i = 0; i < 3; i++) c(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Program 07:30.
    for (int i = 0; i < 7; i++) begin a(0, 1, 2, 1, 0, 0); a(0, 1, 2, 0, 0, 0); end
    for (int i = 0; i < 30; i++) begin a(0, 1, 1, 1, 0, 0); a(0, 1, 1, 0, 0, 0); end
    e_am = 30; e_ah = 7;
    c(T(7, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0);
    c(T(7, 29, 59), 1, 0, 0, 0, 0, 0, 0, 0);
    c(T(7, 30, 0), 1, 0, 0, 0, 0, 1, 0, 0);
    c(T(7, 30, 0), 1, 0, 0, 0, 0, 1, 0, 1);
    c(T(7, 30, 1), 1, 0, 0, 0, 0, 1, 0, 0);
    c(T(7, 30, 2), 1, 0, 0, 0, 0, 1, 0, 1);
    c(T(7, 30, 3), 1, 0, 0, 0, 0, 0, 0, 0);   // third tick ends the ring
    c(T(7, 30, 3), 1, 0, 0, 0, 0, 0, 0, 0);
    c(T(7, 30, 4), 1, 0, 0, 0, 0, 0, 0, 0);

    // Snooze for exactly 300 ticks, then dismiss.
    c(T(7, 29, 59), 1, 0, 0, 0, 0, 0, 0, 0);
    c(T(7, 30, 0), 1, 0, 0, 0, 0, 1, 0, 0);
    c(T(7, 30, 0), 1, 0, 0, 1, 0, 0, 1, 1);
    c(T(7, 30, 0), 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 300; i++)
      c(T(7, 30, 0) + i, 1, 0, 0, 0, 0, i == 300, i < 300, 0);
    c(T(7, 35, 0), 1, 0, 0, 0, 1, 0, 0, 1);
    c(T(7, 35, 0), 1, 0, 0, 0, 0, 0, 0, 0);

    // Snooze and dismiss together while ringing; enable dropped while snoozing.
    c(T(7, 29, 59), 1, 0, 0, 0, 0, 0, 0, 0);
    c(T(7, 30, 0), 1, 0, 0, 0, 0, 1, 0, 0);
    c(T(7, 30, 0), 1, 0, 0, 1, 1, 0, 0, 1);
    c(T(7, 30, 0), 1, 0, 0, 0, 0, 0, 0, 0);
    c(T(7, 29, 59), 1, 0, 0, 0, 0, 0, 0, 0);
    c(T(7, 30, 0), 1, 0, 0, 0, 0, 1, 0, 0);
    c(T(7, 30, 0), 1, 0, 0, 1, 0, 0, 1, 1);
    c(T(7, 30, 0), 1, 0, 0, 0, 0, 0, 1, 0);
    c(T(7, 30, 0), 0, 0, 0, 0, 0, 0, 0, 0);
    c(T(7, 30, 0), 1, 0, 0, 0, 0, 0, 0, 0);

    // Field wraps, unselected field, held increment.
    t = T(12, 0, 30);
    for (int i = 0; i < 29; i++) begin a(t, 1, 1, 1, 0, 0); a(t, 1, 1, 0, 0, 0); end
    e_am = 59;
    c(t, 1, 1, 0, 0, 0, 0, 0, 0);
    e_am = 0;
    c(t, 1, 1, 1, 0, 0, 0, 0, 0);
    a(t, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin a(t, 1, 2, 1, 0, 0); a(t, 1, 2, 0, 0, 0); end
    e_ah = 23;
    c(t, 1, 2, 0, 0, 0, 0, 0, 0);
    e_ah = 0;
    c(t, 1, 2, 1, 0, 0, 0, 0, 0);
    a(t, 1, 2, 0, 0, 0);
    c(t, 1, 3, 1, 0, 0, 0, 0, 0);
    c(t, 1, 3, 0, 0, 0, 0, 0, 0);
    e_am = 1;
    for (int i = 0; i < 4; i++) c(t, 1, 1, 1, 0, 0, 0, 0, 0);
    c(t, 1, 1, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) step(tbl[i], "vec", i);

    // Random traffic with occasional jumps to just before the alarm time.
    t = T(6, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) t = (m_alarm * 60 + 86400 - 2) % 86400;
      else if (r < 60) t = (t + 1) % 86400;
      v.rst = ($urandom_range(0, 499) == 0);
      v.t   = t;
      v.en  = ($urandom_range(0, 199) != 0);
      v.sel = 2'($urandom_range(0, 3));
      v.inc = ($urandom_range(0, 9) == 0);
      v.snz = ($urandom_range(0, 29) == 0);
      v.dis = ($urandom_range(0, 299) == 0);
      v.chk = 1'b0; v.ring = 0; v.snzg = 0; v.buzz = 0; v.am = 0; v.ah = 0;
      step(v, "rnd", k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
